img_window_scanner: RTL and testbench

Initiator for the 2x2 image-window read port of the image memory. On `start` it walks every 2x2 window position of an `N_R` x `N_C` image in raster order. For each position it drives `mem_en`, `mem_addr1` (row) and `mem_addr2` (column), captures the four returned pixels one cycle later, and presents them to the downstream convolution/pooling stage over a valid/ready handshake. It sits between the image memory and the first compute stage of the CNN core.

---
 rtl/img_scan_pkg.sv | 33 +++
 rtl/img_window_scanner_win_max4.sv | 37 +++
 rtl/img_window_scanner.sv | 174 +++++++++++++++++
 tb/tb_img_window_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_scan_pkg.sv
// Shared types and helpers for the 2x2 image-window scanner.
// The optional max-pool comparator is enabled by IMG_SCAN_MAXPOOL_EN.
package img_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } scan_state_e;

  localparam int DEF_N_C    = 5;
  localparam int DEF_N_R    = 3;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_STRIDE = 1;

  // Operands are sign-extended to this width so one helper serves any DATA_W up to 64.
  localparam int MAX2_W = 64;

  function automatic logic signed [MAX2_W-1:0] max2(
    input logic signed [MAX2_W-1:0] a,
    input logic signed [MAX2_W-1:0] b
  );
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/img_window_scanner_win_max4.sv
// Two-level signed compare tree over the four window pixels.
// Only compiled when IMG_SCAN_MAXPOOL_EN is defined.
`ifdef IMG_SCAN_MAXPOOL_EN
module win_max4
  import img_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] max_val
);

  logic signed [MAX2_W-1:0] a_s;
  logic signed [MAX2_W-1:0] b_s;
  logic signed [MAX2_W-1:0] c_s;
  logic signed [MAX2_W-1:0] d_s;
  logic signed [MAX2_W-1:0] ab_s;
  logic signed [MAX2_W-1:0] cd_s;
  logic signed [MAX2_W-1:0] abcd_s;

  // Sign-extend, then reduce pairwise.
  always_comb begin
    a_s     = {{(MAX2_W-DATA_W){a[DATA_W-1]}}, a};
    b_s     = {{(MAX2_W-DATA_W){b[DATA_W-1]}}, b};
    c_s     = {{(MAX2_W-DATA_W){c[DATA_W-1]}}, c};
    d_s     = {{(MAX2_W-DATA_W){d[DATA_W-1]}}, d};
    ab_s    = max2(a_s, b_s);
    cd_s    = max2(c_s, d_s);
    abcd_s  = max2(ab_s, cd_s);
    max_val = abcd_s[DATA_W-1:0];
  end

endmodule
`endif

// File: rtl/img_window_scanner.sv
// Raster-order 2x2 window read initiator with a valid/ready output stage.
// Define IMG_SCAN_MAXPOOL_EN to add the registered signed win_max output.
module img_window_scanner
  import img_scan_pkg::*;
#(
  parameter int N_C    = DEF_N_C,
  parameter int N_R    = DEF_N_R,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2,
  input  logic [DATA_W-1:0] mem_rdata3,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win_d0,
  output logic [DATA_W-1:0] win_d1,
  output logic [DATA_W-1:0] win_d2,
  output logic [DATA_W-1:0] win_d3,
  output logic              win_last
`ifdef IMG_SCAN_MAXPOOL_EN
  ,
  output logic [DATA_W-1:0] win_max
`endif
);

  // Position arithmetic is done two bits wider so row/col + STRIDE cannot wrap.
  localparam logic [ADDR_W+1:0] STEP    = (ADDR_W+2)'(STRIDE);
  localparam logic [ADDR_W+1:0] ROW_MAX = (ADDR_W+2)'(N_R-2);
  localparam logic [ADDR_W+1:0] COL_MAX = (ADDR_W+2)'(N_C-2);

  scan_state_e       state_r;
  scan_state_e       state_next_s;
  logic [ADDR_W-1:0] row_r;
  logic [ADDR_W-1:0] col_r;
  logic [ADDR_W-1:0] row_adv_s;
  logic [ADDR_W-1:0] col_adv_s;
  logic [ADDR_W+1:0] row_inc_s;
  logic [ADDR_W+1:0] col_inc_s;
  logic              last_pos_s;
  logic              accept_s;
  logic              start_s;
  logic              capture_s;

  assign mem_addr1 = row_r;
  assign mem_addr2 = col_r;
  assign accept_s  = (state_r == OUT) && win_ready;
  assign start_s   = (state_r == IDLE) && start;
  assign capture_s = (state_r == WAIT);

  // Next raster position and end-of-image detection.
  always_comb begin
    row_inc_s  = {2'b00, row_r} + STEP;
    col_inc_s  = {2'b00, col_r} + STEP;
    last_pos_s = (row_inc_s > ROW_MAX) && (col_inc_s > COL_MAX);
    if (col_inc_s > COL_MAX) begin
      col_adv_s = {ADDR_W{1'b0}};
      row_adv_s = row_inc_s[ADDR_W-1:0];
    end else begin
      col_adv_s = col_inc_s[ADDR_W-1:0];
      row_adv_s = row_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ:  state_next_s = WAIT;
      WAIT: state_next_s = OUT;
      OUT: begin
        if (win_ready && win_last) begin
          state_next_s = DONE;
        end else if (win_ready) begin
          state_next_s = REQ;
        end else begin
          state_next_s = OUT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and control outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      mem_en    <= (state_next_s == REQ);
      busy      <= (state_next_s == REQ) || (state_next_s == WAIT) ||
                   (state_next_s == OUT);
      done      <= (state_next_s == DONE);
      win_valid <= (state_next_s == OUT);
    end
  end

  // Window position: cleared on start, stepped on each accepted non-final window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_r <= {ADDR_W{1'b0}};
      col_r <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      row_r <= {ADDR_W{1'b0}};
      col_r <= {ADDR_W{1'b0}};
    end else if (accept_s && !win_last) begin
      row_r <= row_adv_s;
      col_r <= col_adv_s;
    end
  end

  // Pixel capture in WAIT; held until the next capture so OUT sees stable data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_d0   <= {DATA_W{1'b0}};
      win_d1   <= {DATA_W{1'b0}};
      win_d2   <= {DATA_W{1'b0}};
      win_d3   <= {DATA_W{1'b0}};
      win_last <= 1'b0;
    end else if (capture_s) begin
      win_d0   <= mem_rdata0;
      win_d1   <= mem_rdata1;
      win_d2   <= mem_rdata2;
      win_d3   <= mem_rdata3;
      win_last <= last_pos_s;
    end
  end

`ifdef IMG_SCAN_MAXPOOL_EN
  logic [DATA_W-1:0] max_s;

  win_max4 #(
    .DATA_W (DATA_W)
  ) u_win_max4 (
    .a       (mem_rdata0),
    .b       (mem_rdata1),
    .c       (mem_rdata2),
    .d       (mem_rdata3),
    .max_val (max_s)
  );

  // Max is captured alongside the pixels, adding no latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_max <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      win_max <= max_s;
    end
  end
`endif

endmodule

// File: tb/tb_img_window_scanner.sv
// Randomized self-checking bench for img_window_scanner (stride 1 and stride 2 instances).
// Checks win_max as well when IMG_SCAN_MAXPOOL_EN is defined.
module tb_img_window_scanner;

  localparam int N_C   = 5;
  localparam int N_R   = 3;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int TOT_A = ((N_R-2)/1 + 1) * ((N_C-2)/1 + 1);
  localparam int TOT_B = ((N_R-2)/2 + 1) * ((N_C-2)/2 + 1);

  logic clk;
  logic rst_n, start, win_ready, start_b;
  logic busy, done, mem_en, win_valid, win_last;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] rd0, rd1, rd2, rd3, win_d0, win_d1, win_d2, win_d3;
  logic b_busy, b_done, b_mem_en, b_win_valid, b_win_last;
  logic [AW-1:0] b_addr1, b_addr2;
  logic [DW-1:0] b_rd0, b_rd1, b_rd2, b_rd3, b_d0, b_d1, b_d2, b_d3;
`ifdef IMG_SCAN_MAXPOOL_EN
  logic [DW-1:0] win_max, b_win_max;
`endif

  int n_err = 0, n_checks = 0;
  int k_a = 0, k_b = 0, done_cnt = 0, done_cnt_b = 0;
  bit prev_en = 1'b0, prev_en_b = 1'b0, hold_a = 1'b0;
  logic [DW-1:0] h_d0, h_d1, h_d2, h_d3;
  logic          h_last;

  img_window_scanner #(.N_C(N_C), .N_R(N_R), .ADDR_W(AW), .DATA_W(DW), .STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_rdata0(rd0), .mem_rdata1(rd1), .mem_rdata2(rd2), .mem_rdata3(rd3),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_d0(win_d0), .win_d1(win_d1), .win_d2(win_d2), .win_d3(win_d3),
    .win_last(win_last)
`ifdef IMG_SCAN_MAXPOOL_EN
    , .win_max(win_max)
`endif
  );

  img_window_scanner #(.N_C(N_C), .N_R(N_R), .ADDR_W(AW), .DATA_W(DW), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .mem_en(b_mem_en), .mem_addr1(b_addr1), .mem_addr2(b_addr2),
    .mem_rdata0(b_rd0), .mem_rdata1(b_rd1), .mem_rdata2(b_rd2), .mem_rdata3(b_rd3),
    .win_valid(b_win_valid), .win_ready(1'b1),
    .win_d0(b_d0), .win_d1(b_d1), .win_d2(b_d2), .win_d3(b_d3),
    .win_last(b_win_last)
`ifdef IMG_SCAN_MAXPOOL_EN
    , .win_max(b_win_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pix(input int r, input int c);
    return 6 - (r * N_C + c);
  endfunction

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Window k in raster order for a given stride.
  function automatic int exp_r(input int k, input int s);
    return (k / ((N_C-2)/s + 1)) * s;
  endfunction

  function automatic int exp_c(input int k, input int s);
    return (k % ((N_C-2)/s + 1)) * s;
  endfunction

  // Image memory: one-cycle latency, garbage when not enabled.
  always @(posedge clk) begin
    if (mem_en) begin
      rd0 <= DW'(pix(int'(mem_addr1), int'(mem_addr2)));
      rd1 <= DW'(pix(int'(mem_addr1), int'(mem_addr2) + 1));
      rd2 <= DW'(pix(int'(mem_addr1) + 1, int'(mem_addr2)));
      rd3 <= DW'(pix(int'(mem_addr1) + 1, int'(mem_addr2) + 1));
    end else begin
      rd0 <= DW'($urandom); rd1 <= DW'($urandom);
      rd2 <= DW'($urandom); rd3 <= DW'($urandom);
    end
    if (b_mem_en) begin
      b_rd0 <= DW'(pix(int'(b_addr1), int'(b_addr2)));
      b_rd1 <= DW'(pix(int'(b_addr1), int'(b_addr2) + 1));
      b_rd2 <= DW'(pix(int'(b_addr1) + 1, int'(b_addr2)));
      b_rd3 <= DW'(pix(int'(b_addr1) + 1, int'(b_addr2) + 1));
    end else begin
      b_rd0 <= DW'($urandom); b_rd1 <= DW'($urandom);
      b_rd2 <= DW'($urandom); b_rd3 <= DW'($urandom);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitors the current cycle against the reference model, then advances one clock.
  task automatic tick();
    int r, c;
    if (mem_en === 1'b1) begin
      check("mem_en_gap", int'(prev_en), 0);
      if (k_a < TOT_A) begin
        check("addr1", int'(mem_addr1), exp_r(k_a, 1));
        check("addr2", int'(mem_addr2), exp_c(k_a, 1));
      end else begin
        check("mem_en_extra", 1, 0);
      end
    end
    prev_en = (mem_en === 1'b1);
    if (win_valid === 1'b1 && win_ready === 1'b0) begin
      if (hold_a) begin
        check("stable_d0", sx(win_d0), sx(h_d0));
        check("stable_d3", sx(win_d3), sx(h_d3));
        check("stable_last", int'(win_last), int'(h_last));
      end
      h_d0 = win_d0; h_d1 = win_d1; h_d2 = win_d2; h_d3 = win_d3; h_last = win_last;
      hold_a = 1'b1;
    end else begin
      hold_a = 1'b0;
    end
    if (win_valid === 1'b1 && win_ready === 1'b1) begin
      if (k_a < TOT_A) begin
        r = exp_r(k_a, 1); c = exp_c(k_a, 1);
        check("win_d0", sx(win_d0), pix(r, c));
        check("win_d1", sx(win_d1), pix(r, c + 1));
        check("win_d2", sx(win_d2), pix(r + 1, c));
        check("win_d3", sx(win_d3), pix(r + 1, c + 1));
        check("win_last", int'(win_last), int'(k_a == TOT_A - 1));
`ifdef IMG_SCAN_MAXPOOL_EN
        check("win_max", sx(win_max),
              max4(pix(r, c), pix(r, c + 1), pix(r + 1, c), pix(r + 1, c + 1)));
`endif
        k_a++;
      end else begin
        check("win_extra", 1, 0);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_all_windows", k_a, TOT_A);
    end
    if (b_mem_en === 1'b1) begin
      check("b_mem_en_gap", int'(prev_en_b), 0);
      check("b_addr2", int'(b_addr2), exp_c(k_b, 2));
    end
    prev_en_b = (b_mem_en === 1'b1);
    if (b_win_valid === 1'b1) begin
      r = exp_r(k_b, 2); c = exp_c(k_b, 2);
      check("b_win_d0", sx(b_d0), pix(r, c));
      check("b_win_d3", sx(b_d3), pix(r + 1, c + 1));
      check("b_win_last", int'(b_win_last), int'(k_b == TOT_B - 1));
      k_b++;
    end
    if (b_done === 1'b1) begin
      done_cnt_b++;
      check("b_done_windows", k_b, TOT_B);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, held;
    bit fin;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; win_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_valid", int'(win_valid), 0);
    check("rst_addr1", int'(mem_addr1), 0);
    check("rst_addr2", int'(mem_addr2), 0);
    check("rst_d0", sx(win_d0), 0);
    check("rst_last", int'(win_last), 0);
    rst_n = 1'b1;
    tick();

    // Full scan with ready held high; stride-2 instance runs alongside.
    k_a = 0; k_b = 0;
    start = 1'b1; start_b = 1'b1; tick(); start = 1'b0; start_b = 1'b0;
    check("start_mem_en", int'(mem_en), 1);
    check("start_busy", int'(busy), 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    check("scan_cycles", n, 24);
    check("done_busy", int'(busy), 0);
    check("b_windows", k_b, TOT_B);
    tick();
    check("done_pulse", int'(done), 0);

    // Backpressure on window (0,2); start pulses mid-scan and in the DONE cycle.
    k_a = 0; held = 0; fin = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!fin && n < 200) begin
      if (win_valid === 1'b1 && k_a == 2 && held < 5) begin
        win_ready = 1'b0; held++;
        check("hold_d0", sx(win_d0), 4);
        check("hold_d1", sx(win_d1), 3);
        check("hold_d2", sx(win_d2), -1);
        check("hold_d3", sx(win_d3), -2);
        check("hold_mem_en", int'(mem_en), 0);
      end else begin
        win_ready = 1'b1;
      end
      start = (n == 10);
      if (done === 1'b1) begin start = 1'b1; fin = 1'b1; end
      tick(); n++;
    end
    start = 1'b0;
    check("hold_cycles", held, 5);
    check("hold_scan_done", int'(fin), 1);
    repeat (8) tick();
    check("hold_windows", k_a, TOT_A);
    check("idle_busy", int'(busy), 0);

    // Random backpressure.
    k_a = 0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      win_ready = 1'($urandom_range(0, 1)); tick(); n++;
    end
    check("rand_done", int'(done), 1);
    tick();

    // Reset during window (1,1), then restart.
    win_ready = 1'b1; k_a = 0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(win_valid === 1'b1 && k_a == 5) && n < 100) begin tick(); n++; end
    check("rst_reach_11", int'(win_valid === 1'b1 && k_a == 5), 1);
    win_ready = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
    k_a = 0;
    check("mid_rst_valid", int'(win_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_addr1", int'(mem_addr1), 0);
    check("mid_rst_addr2", int'(mem_addr2), 0);
    check("mid_rst_done", int'(done), 0);
    repeat (5) tick();
    win_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("restart_mem_en", int'(mem_en), 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    check("restart_done", int'(done), 1);
    tick();

    check("done_count", done_cnt, 4);
    check("b_done_count", done_cnt_b, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
